// File: rtl/fwd_data_path.sv
// Forwarding data path: result pipeline EX->MA->WB->post-WB, one-hot operand select and stall hold.
// Optional sticky multi-hit checker enabled by defining FWD_ONEHOT_CHK_EN.
module fwd_data_path #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_rst_pipe,
  input  logic            i_stall,
  input  logic            i_stall_ma,
  input  logic            i_stall_wb,
  input  logic [XLEN-1:0] i_alu_result_ex,
  input  logic            i_wbk_rd_reg_ex,
  input  logic            i_cmd_ld_ma,
  input  logic [XLEN-1:0] i_ld_data_ma,
  input  logic            i_hit_rs1_idex_ex,
  input  logic            i_hit_rs1_idma_ex,
  input  logic            i_hit_rs1_idwb_ex,
  input  logic            i_nohit_rs1_ex,
  input  logic            i_hit_rs2_idex_ex,
  input  logic            i_hit_rs2_idma_ex,
  input  logic            i_hit_rs2_idwb_ex,
  input  logic            i_nohit_rs2_ex,
  input  logic [XLEN-1:0] i_rf_rs1_data_ex,
  input  logic [XLEN-1:0] i_rf_rs2_data_ex,
  output logic [XLEN-1:0] o_rs1_opr_ex,
  output logic [XLEN-1:0] o_rs2_opr_ex,
  output logic [XLEN-1:0] o_rd_data_wb,
  output logic            o_fwd_err
);

  logic [XLEN-1:0] r_rd_data_ma;
  logic [XLEN-1:0] r_rd_data_wb;
  logic [XLEN-1:0] r_rd_data_post;
  logic [XLEN-1:0] r_hold_rs1;
  logic [XLEN-1:0] r_hold_rs2;
  logic            r_hold_valid;
  logic [XLEN-1:0] w_sel_rs1;
  logic [XLEN-1:0] w_sel_rs2;

  // Nearest producer wins; an all-zero flag set (post-load bubble) falls back to the register file.
  function automatic logic [XLEN-1:0] sel_opr(
    input logic            idex,
    input logic            idma,
    input logic            idwb,
    input logic            nohit,
    input logic [XLEN-1:0] ma,
    input logic [XLEN-1:0] wb,
    input logic [XLEN-1:0] post,
    input logic [XLEN-1:0] rf
  );
    logic [XLEN-1:0] res;
    if (idex)       res = ma;
    else if (idma)  res = wb;
    else if (idwb)  res = post;
    else if (nohit) res = rf;
    else            res = rf;
    return res;
  endfunction

  assign w_sel_rs1 = sel_opr(i_hit_rs1_idex_ex, i_hit_rs1_idma_ex, i_hit_rs1_idwb_ex,
                             i_nohit_rs1_ex, r_rd_data_ma, r_rd_data_wb, r_rd_data_post,
                             i_rf_rs1_data_ex);
  assign w_sel_rs2 = sel_opr(i_hit_rs2_idex_ex, i_hit_rs2_idma_ex, i_hit_rs2_idwb_ex,
                             i_nohit_rs2_ex, r_rd_data_ma, r_rd_data_wb, r_rd_data_post,
                             i_rf_rs2_data_ex);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data_ma   <= '0;
      r_rd_data_wb   <= '0;
      r_rd_data_post <= '0;
    end else if (i_rst_pipe) begin
      r_rd_data_ma   <= '0;
      r_rd_data_wb   <= '0;
      r_rd_data_post <= '0;
    end else if (!i_stall) begin
      r_rd_data_ma <= i_wbk_rd_reg_ex ? i_alu_result_ex : '0;
      if (!i_stall_ma) r_rd_data_wb <= i_cmd_ld_ma ? i_ld_data_ma : r_rd_data_ma;
      if (!i_stall_wb) r_rd_data_post <= r_rd_data_wb;
    end
  end

  // Operands seen in the first stalled cycle are frozen; later producers keep retiring meanwhile.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_rs1   <= '0;
      r_hold_rs2   <= '0;
    end else if (i_rst_pipe) begin
      r_hold_valid <= 1'b0;
      r_hold_rs1   <= '0;
      r_hold_rs2   <= '0;
    end else if (i_stall) begin
      r_hold_valid <= 1'b1;
      if (!r_hold_valid) begin
        r_hold_rs1 <= w_sel_rs1;
        r_hold_rs2 <= w_sel_rs2;
      end
    end else begin
      r_hold_valid <= 1'b0;
    end
  end

  assign o_rs1_opr_ex = r_hold_valid ? r_hold_rs1 : w_sel_rs1;
  assign o_rs2_opr_ex = r_hold_valid ? r_hold_rs2 : w_sel_rs2;
  assign o_rd_data_wb = r_rd_data_wb;

`ifdef FWD_ONEHOT_CHK_EN
  logic       r_fwd_err;
  logic [2:0] w_cnt_rs1;
  logic [2:0] w_cnt_rs2;

  assign w_cnt_rs1 = 3'(i_hit_rs1_idex_ex) + 3'(i_hit_rs1_idma_ex)
                   + 3'(i_hit_rs1_idwb_ex) + 3'(i_nohit_rs1_ex);
  assign w_cnt_rs2 = 3'(i_hit_rs2_idex_ex) + 3'(i_hit_rs2_idma_ex)
                   + 3'(i_hit_rs2_idwb_ex) + 3'(i_nohit_rs2_ex);

  // Sticky until power-on reset so a flush cannot hide a detector fault.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fwd_err <= 1'b0;
    end else if (!i_stall && ((w_cnt_rs1 > 3'd1) || (w_cnt_rs2 > 3'd1))) begin
      r_fwd_err <= 1'b1;
    end
  end

  assign o_fwd_err = r_fwd_err;
`else
  assign o_fwd_err = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_data_path.sv
// Self-checking bench for fwd_data_path: stage-history model checked every cycle plus directed literal checks.
module tb_fwd_data_path;

   localparam int XLEN = 32;
`ifdef FWD_ONEHOT_CHK_EN
   localparam bit errEn = 1'b1;
`else
   localparam bit errEn = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rstN;
   logic            rstPipe, stall, stallMa, stallWb;
   logic [XLEN-1:0] aluResult, ldData, rf1Data, rf2Data;
   logic            wbkRd, cmdLd;
   logic [3:0]      rs1Flags, rs2Flags;
   logic [XLEN-1:0] rs1Opr, rs2Opr, rdDataWb;
   logic            fwdErr;

   int total = 0;
   int bad   = 0;
   bit checkEn = 1'b0;

   // Model state: results one, two and three stages past EX, plus the frozen operand pair.
   logic [XLEN-1:0] mMa, mWb, mPost, mHold1, mHold2;
   logic            mHoldValid, mErr;

   always #5 clk = ~clk;

   fwd_data_path #(.XLEN(XLEN)) dut (
      .i_clk(clk), .i_rst_n(rstN), .i_rst_pipe(rstPipe), .i_stall(stall),
      .i_stall_ma(stallMa), .i_stall_wb(stallWb),
      .i_alu_result_ex(aluResult), .i_wbk_rd_reg_ex(wbkRd),
      .i_cmd_ld_ma(cmdLd), .i_ld_data_ma(ldData),
      .i_hit_rs1_idex_ex(rs1Flags[3]), .i_hit_rs1_idma_ex(rs1Flags[2]),
      .i_hit_rs1_idwb_ex(rs1Flags[1]), .i_nohit_rs1_ex(rs1Flags[0]),
      .i_hit_rs2_idex_ex(rs2Flags[3]), .i_hit_rs2_idma_ex(rs2Flags[2]),
      .i_hit_rs2_idwb_ex(rs2Flags[1]), .i_nohit_rs2_ex(rs2Flags[0]),
      .i_rf_rs1_data_ex(rf1Data), .i_rf_rs2_data_ex(rf2Data),
      .o_rs1_opr_ex(rs1Opr), .o_rs2_opr_ex(rs2Opr), .o_rd_data_wb(rdDataWb),
      .o_fwd_err(fwdErr)
   );

   // Flags {idex,idma,idwb,nohit} map to producers at distance 1,2,3 and then the register file.
   function automatic logic [XLEN-1:0] pickOpr(input logic [3:0] flags, input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] ma, input logic [XLEN-1:0] wb,
                                               input logic [XLEN-1:0] post);
      logic [XLEN-1:0] src [4];
      src[0] = ma; src[1] = wb; src[2] = post; src[3] = rf;
      for (int i = 0; i < 4; i++)
         if (flags[3-i]) return src[i];
      return rf;
   endfunction

   task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [XLEN-1:0] alu, input logic wbk, input logic ld,
                                input logic [XLEN-1:0] ldd, input logic [3:0] f1, input logic [3:0] f2,
                                input logic [XLEN-1:0] rf1, input logic [XLEN-1:0] rf2,
                                input logic st, input logic stMa, input logic stWb, input logic rp);
      aluResult = alu; wbkRd = wbk; cmdLd = ld; ldData = ldd;
      rs1Flags = f1; rs2Flags = f2; rf1Data = rf1; rf2Data = rf2;
      stall = st; stallMa = stMa; stallWb = stWb; rstPipe = rp;
   endtask

   task automatic waitEdge();
      @(posedge clk);
      #2;
   endtask

   // Model advances on each edge from the inputs that were stable before it.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         mMa = '0; mWb = '0; mPost = '0; mHold1 = '0; mHold2 = '0;
         mHoldValid = 1'b0; mErr = 1'b0;
      end else begin
         if (errEn && !stall && ($countones(rs1Flags) > 1 || $countones(rs2Flags) > 1)) mErr = 1'b1;
         if (rstPipe) begin
            mMa = '0; mWb = '0; mPost = '0; mHold1 = '0; mHold2 = '0; mHoldValid = 1'b0;
         end else if (stall) begin
            if (!mHoldValid) begin
               mHold1 = pickOpr(rs1Flags, rf1Data, mMa, mWb, mPost);
               mHold2 = pickOpr(rs2Flags, rf2Data, mMa, mWb, mPost);
            end
            mHoldValid = 1'b1;
         end else begin
            mHoldValid = 1'b0;
            if (!stallWb) mPost = mWb;
            if (!stallMa) mWb = cmdLd ? ldData : mMa;
            mMa = wbkRd ? aluResult : '0;
         end
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("model_rs1", rs1Opr, mHoldValid ? mHold1 : pickOpr(rs1Flags, rf1Data, mMa, mWb, mPost));
         checkOutput("model_rs2", rs2Opr, mHoldValid ? mHold2 : pickOpr(rs2Flags, rf2Data, mMa, mWb, mPost));
         checkOutput("model_rdwb", rdDataWb, mWb);
         checkOutput("model_err", {31'd0, fwdErr}, {31'd0, mErr});
      end
   end

   initial begin
      rstN = 1'b0;
      applyStimulus('0, 0, 0, '0, 4'b0001, 4'b0001, '0, '0, 0, 0, 0, 0);
      #3;
      checkOutput("reset_rs1", rs1Opr, 32'h0);
      checkOutput("reset_rs2", rs2Opr, 32'h0);
      checkOutput("reset_rdwb", rdDataWb, 32'h0);
      checkOutput("reset_err", {31'd0, fwdErr}, 32'h0);
      waitEdge();
      waitEdge();
      rstN = 1'b1;
      checkEn = 1'b1;

      // EX->EX forward
      applyStimulus(32'h1234, 1, 0, '0, 4'b0001, 4'b0001, '0, '0, 0, 0, 0, 0);
      waitEdge();
      applyStimulus('0, 0, 0, '0, 4'b1000, 4'b0001, 32'h5, 32'h6, 0, 0, 0, 0);
      #1 checkOutput("exex_rs1", rs1Opr, 32'h1234);
      checkOutput("exex_rs2_rf", rs2Opr, 32'h6);

      // Load then use
      applyStimulus('0, 0, 1, 32'hDEADBEEF, 4'b0001, 4'b0001, '0, '0, 0, 0, 0, 0);
      waitEdge();
      applyStimulus('0, 0, 0, '0, 4'b0001, 4'b0100, '0, '0, 0, 0, 0, 0);
      #1 checkOutput("load_rs2", rs2Opr, 32'hDEADBEEF);
      checkOutput("load_rdwb", rdDataWb, 32'hDEADBEEF);

      // WB+1 forward
      applyStimulus('0, 0, 1, 32'h55, 4'b0001, 4'b0001, '0, '0, 0, 0, 0, 0);
      waitEdge();
      applyStimulus('0, 0, 0, '0, 4'b0001, 4'b0001, '0, '0, 0, 0, 0, 0);
      waitEdge();
      applyStimulus('0, 0, 0, '0, 4'b0010, 4'b0001, '0, '0, 0, 0, 0, 0);
      #1 checkOutput("wb1_rs1", rs1Opr, 32'h55);

      // Stall hold across three stalled cycles while inputs change
      applyStimulus(32'hA, 1, 0, '0, 4'b0001, 4'b0001, '0, '0, 0, 0, 0, 0);
      waitEdge();
      applyStimulus(32'hBB, 1, 0, '0, 4'b1000, 4'b0001, '0, '0, 1, 0, 0, 0);
      #1 checkOutput("hold_c1", rs1Opr, 32'hA);
      waitEdge();
      applyStimulus(32'hCC, 1, 0, '0, 4'b0001, 4'b0001, 32'h77, '0, 1, 0, 0, 0);
      #1 checkOutput("hold_c2", rs1Opr, 32'hA);
      waitEdge();
      #1 checkOutput("hold_c3", rs1Opr, 32'hA);
      waitEdge();
      applyStimulus(32'hCC, 1, 0, '0, 4'b0001, 4'b0001, 32'h77, '0, 0, 0, 0, 0);
      #1 checkOutput("hold_release_cycle", rs1Opr, 32'hA);
      waitEdge();
      #1 checkOutput("hold_after", rs1Opr, 32'h77);

      // Flush in the middle of a stall
      applyStimulus(32'h11, 1, 0, '0, 4'b0001, 4'b0001, '0, '0, 0, 0, 0, 0);
      waitEdge();
      applyStimulus('0, 0, 0, '0, 4'b1000, 4'b0001, '0, '0, 1, 0, 0, 0);
      #1 checkOutput("flush_pre", rs1Opr, 32'h11);
      waitEdge();
      applyStimulus('0, 0, 0, '0, 4'b1000, 4'b0001, '0, '0, 1, 0, 0, 1);
      waitEdge();
      applyStimulus('0, 0, 0, '0, 4'b1000, 4'b0001, '0, 32'h99, 0, 0, 0, 0);
      #1 checkOutput("flush_rs1_ma", rs1Opr, 32'h0);
      checkOutput("flush_rs2_rf", rs2Opr, 32'h99);
      checkOutput("flush_rdwb", rdDataWb, 32'h0);

      // Multi-hit while stalled must not flag
      applyStimulus('0, 0, 0, '0, 4'b1010, 4'b0001, '0, '0, 1, 0, 0, 0);
      waitEdge();
      applyStimulus('0, 0, 0, '0, 4'b0001, 4'b0001, '0, '0, 0, 0, 0, 0);
      #1 checkOutput("err_stalled", {31'd0, fwdErr}, 32'h0);
      waitEdge();

      // Multi-hit in a running cycle, then flush, then power-on reset
      applyStimulus('0, 0, 0, '0, 4'b1100, 4'b0001, '0, '0, 0, 0, 0, 0);
      waitEdge();
      applyStimulus('0, 0, 0, '0, 4'b0001, 4'b0001, '0, '0, 0, 0, 0, 0);
      #1 checkOutput("err_set", {31'd0, fwdErr}, {31'd0, errEn});
      applyStimulus('0, 0, 0, '0, 4'b0001, 4'b0001, '0, '0, 0, 0, 0, 1);
      waitEdge();
      applyStimulus('0, 0, 0, '0, 4'b0001, 4'b0001, '0, '0, 0, 0, 0, 0);
      #1 checkOutput("err_after_flush", {31'd0, fwdErr}, {31'd0, errEn});
      rstN = 1'b0;
      #1 checkOutput("err_after_rst", {31'd0, fwdErr}, 32'h0);
      waitEdge();
      rstN = 1'b1;

      // Stalled MA/WB keep their results while the front advances
      applyStimulus(32'h42, 1, 1, 32'h3C, 4'b0001, 4'b0001, '0, '0, 0, 0, 0, 0);
      waitEdge();
      applyStimulus(32'h43, 1, 0, '0, 4'b0010, 4'b0100, '0, '0, 0, 1, 1, 0);
      waitEdge();
      applyStimulus('0, 0, 0, '0, 4'b0100, 4'b1000, '0, '0, 0, 0, 0, 0);
      #1 checkOutput("stallma_rdwb", rdDataWb, 32'h3C);
      checkOutput("stallma_rs2_ma", rs2Opr, 32'h43);
      waitEdge();
      waitEdge();

      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fwd_data_path.md
Name: fwd_data_path

Overview:
- Data-side counterpart of the forwarding hazard detector.
- Holds producer results as they move EX→MA→WB→post-WB, and delivers the selected rs1/rs2 operand to the EX stage when the registered hit flags arrive.
- Freezes the chosen operands across a stall, because producers keep retiring while the consumer waits.
- Sits between the EX/MA/WB datapath and the ALU operand inputs.

Parameters:
- XLEN, 32, data width of operands and results.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rst_pipe  in  1  synchronous pipeline flush
- stall  in  1  global pipeline stall
- stall_ma  in  1  MA stage bubble/stall
- stall_wb  in  1  WB stage bubble/stall
- alu_result_ex  in  XLEN  EX-stage result of the producer
- wbk_rd_reg_ex  in  1  EX instruction writes rd
- cmd_ld_ma  in  1  MA instruction is a load
- ld_data_ma  in  XLEN  load data returned in MA
- hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex  in  1 each  rs1 select flags
- hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex  in  1 each  rs2 select flags
- rf_rs1_data_ex  in  XLEN  register-file rs1 value, already in EX
- rf_rs2_data_ex  in  XLEN  register-file rs2 value, already in EX
- rs1_opr_ex  out  XLEN  forwarded rs1 operand
- rs2_opr_ex  out  XLEN  forwarded rs2 operand
- rd_data_wb  out  XLEN  WB write data to the register file
- fwd_err  out  1  sticky multi-hit error (optional feature only; tie 0 otherwise)

Behaviour:
- Reset: rst_n low clears all registers to 0 asynchronously.
  - Outputs after reset: rs1_opr_ex=0, rs2_opr_ex=0, rd_data_wb=0, fwd_err=0.
- rst_pipe: clears rd_data_ma, rd_data_wb, rd_data_post, hold_valid and both hold registers. It takes priority over stall.
- Result pipeline, advancing only when stall=0:
  - rd_data_ma <= alu_result_ex when wbk_rd_reg_ex=1, else 0.
  - rd_data_wb <= (cmd_ld_ma ? ld_data_ma : rd_data_ma) when stall_ma=0, else holds its value.
  - rd_data_post <= rd_data_wb when stall_wb=0, else holds its value.
- Operand select is combinational and one-hot. Priority is idex > idma > idwb > nohit:
  - idex → rd_data_ma
  - idma → rd_data_wb
  - idwb → rd_data_post
  - nohit → rf_*_data_ex
- If every flag is 0 (the bubble right after a load stall), the operand is rf_*_data_ex.
- Stall hold:
  - hold_valid is set on the first clk edge with stall=1 and clears on the first edge with stall=0.
  - On the set edge, the hold registers capture the combinational select result.
  - While hold_valid=1, rs*_opr_ex = hold register.
  - Net effect: the operand value from the first stalled cycle is frozen for the whole stall and released the cycle after stall falls.
- Forwarding latency: from producer result in EX to availability on rs*_opr_ex via idex is one clk.
- Simultaneous stall and rst_pipe: rst_pipe wins; hold_valid=0.

Optional Feature:
- Macro FWD_ONEHOT_CHK_EN.
- When defined, fwd_err sets (sticky) when more than one of {idex, idma, idwb, nohit} is 1 for rs1 or for rs2 in a non-stalled cycle. Only rst_n clears it; rst_pipe does not.
- When undefined, fwd_err is constant 0 and no checker logic exists.

Test Plan:
- EX→EX forward: producer alu_result_ex=0x1234, wbk=1. Next cycle hit_rs1_idex_ex=1 → rs1_opr_ex=0x1234.
- Load then use: cmd_ld_ma=1, ld_data_ma=0xDEADBEEF. Next cycle hit_rs2_idma_ex=1 → rs2_opr_ex=0xDEADBEEF and rd_data_wb=0xDEADBEEF.
- WB+1 forward: rd_data_wb=0x55, advanced one cycle with stall_wb=0. Then hit_rs1_idwb_ex=1 → rs1_opr_ex=0x55 while rf_rs1_data_ex=0.
- Stall hold: assert hit_rs1_idex_ex with rd_data_ma=0xA. Raise stall for 3 cycles while alu_result_ex changes → rs1_opr_ex stays 0xA for all 3 cycles and follows normal select 1 cycle after stall drops.
- Flush mid-stall: during stall, assert rst_pipe → next cycle rd_data_ma=rd_data_wb=0, hold released, nohit selects rf data.
- With FWD_ONEHOT_CHK_EN: drive hit_rs1_idex_ex=1 and hit_rs1_idma_ex=1 together → fwd_err=1 next edge. It survives rst_pipe and clears only on rst_n.
